mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//  Responder end of the core's mem_if instruction and data ports: a single-clock, word-organised memory that serves them.
//  One independent imem port (read-only) and one dmem port (byte-enabled write, read), each with a latency counter and hit handshake.
//  Sits under the formal/sim harness beside the core wrapper; replaces the tied-off hit=1 / external-data stub.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words; byte address range 0 .. 4*DEPTH_WORDS-1
//  LATENCY      1     cycles from request accept to hit; legal 1..15
//  BASE_ADDR    32'h0 byte address mapped to word 0
// PORTS
//  clk            in   1   clock
//  reset_n        in   1   synchronous reset, active-low
//  imem_addr      in   32  instruction byte address
//  imem_read_en   in   1   instruction read request
//  imem_data_o    out  32  instruction read data, valid when imem_hit
//  imem_hit       out  1   instruction response strobe
//  dmem_addr      in   32  data byte address
//  dmem_data_i    in   32  write data
//  dmem_write_en  in   1   write request
//  dmem_data_en   in   4   byte enables for writes, bit k -> byte k
//  dmem_read_en   in   1   data read request
//  dmem_data_o    out  32  data read data, valid when dmem_hit
//  dmem_hit       out  1   data response strobe
//  oob_err        out  1   sticky: an access fell outside BASE_ADDR..+4*DEPTH_WORDS
//  proto_err      out  1   sticky: request dropped or changed while pending, or read_en&write_en together
// BEHAVIOUR
//  Reset: all outputs 0, both FSMs IDLE, counters 0. Memory array is not cleared.
//  Reset mid-operation: the pending request is abandoned and no hit is issued.
//  Per-port FSM, states IDLE -> WAIT -> RESP -> IDLE:
//   IDLE: a request (read_en or write_en) is accepted.
//     - LATENCY==1: go straight to RESP and raise hit next cycle.
//     - Otherwise: go to WAIT with cnt=LATENCY-1.
//     - On accept, latch addr, data_i, data_en and op.
//   WAIT: decrement cnt; when cnt reaches 1, go to RESP.
//   RESP: hit=1 for exactly one cycle. data_o is driven this cycle only and is 0 otherwise.
//     - A write commits to the array on the RESP cycle.
//     - Then IDLE. A new request is accepted no earlier than the cycle after RESP.
//     - Consequence: back-to-back throughput is LATENCY+1 cycles per access.
//  Requester rule: hold addr/en/data stable until hit.
//   - A change while in WAIT sets proto_err. The latched values are still used.
//  Addressing: word index = (addr-BASE_ADDR)>>2. addr[1:0] is ignored; accesses are word-aligned.
//  Out of range: reads return 0, writes are dropped, oob_err is set. Hit is still given.
//  Byte writes: mem[w][8k+7:8k] <= data_i[8k+7:8k] only where data_en[k].
//   - data_en==0 is a legal no-op write that still gets a hit.
//  Simultaneous imem read and dmem write to the same word in the same RESP cycle: imem returns the OLD word (read-before-write).
//  dmem read in RESP returns the array contents before that cycle's update. No write-to-read forwarding.
//  Sticky error flags clear only on reset.
// CONFIGURATION
//  MEM_RESPONDER_STALL_INJECT_EN defined:
//   - A 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle.
//   - While a port is in WAIT with cnt==1 and lfsr[0]==1, the port stays in WAIT one more cycle.
//   - Stalls are capped at 7 consecutive extra cycles per request.
//   - Separate LFSR bit per port: imem uses lfsr[0], dmem uses lfsr[1].
//  Undefined: latency is exactly LATENCY cycles and no LFSR is instantiated.
// STRUCTURE
//  Package mem_responder_pkg:
//   - typedef enum logic[1:0] {IDLE, WAIT, RESP} resp_state_t
//   - typedef struct {addr, wdata, be, is_write} mem_req_t
//   - LFSR seed and tap constants
//  Sub-module mem_resp_port: one FSM + latency counter + request latch, instantiated twice (imem with write tied 0).
//  Top level holds the shared array, read-before-write ordering and error flags.
// TESTING
//  1. LATENCY=1, imem read at 0x10 holding 0xDEADBEEF -> imem_hit and data 0xDEADBEEF in cycle 2; hit low in cycle 3.
//  2. dmem write 0x11223344 be=4'b0101 to 0x20 (old 0xFFFFFFFF), then read -> read data 0xFF22FF44.
//  3. LATENCY=3: dmem read held -> hit exactly 3 cycles after accept; next accept no earlier than cycle 4.
//  4. Same cycle, dmem write 0xA5A5A5A5 to 0x40 and imem read of 0x40 (old 0x0) -> imem data 0x0; later read gives 0xA5A5A5A5.
//  5. Read at BASE_ADDR+4*DEPTH_WORDS -> hit with data 0; oob_err=1 and still 1 after 10 idle cycles.
//  6. reset_n low during WAIT -> no hit, all outputs 0 next cycle; data written before reset still readable after.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder instruction/data memory model.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        is_write;
    } mem_req_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the core's mem ports (master) and mem_responder (slave).
interface mem_responder_if;
    logic [31:0] imem_addr;
    logic        imem_read_en;
    logic [31:0] imem_data_o;
    logic        imem_hit;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_data_i;
    logic        dmem_write_en;
    logic [3:0]  dmem_data_en;
    logic        dmem_read_en;
    logic [31:0] dmem_data_o;
    logic        dmem_hit;
    logic        oob_err;
    logic        proto_err;

    modport master (
        output imem_addr, imem_read_en,
        output dmem_addr, dmem_data_i, dmem_write_en, dmem_data_en, dmem_read_en,
        input  imem_data_o, imem_hit, dmem_data_o, dmem_hit, oob_err, proto_err
    );

    modport slave (
        input  imem_addr, imem_read_en,
        input  dmem_addr, dmem_data_i, dmem_write_en, dmem_data_en, dmem_read_en,
        output imem_data_o, imem_hit, dmem_data_o, dmem_hit, oob_err, proto_err
    );
endinterface

// File: rtl/mem_resp_port.sv
// One responder port: request latch, IDLE/WAIT/RESP FSM and latency counter.
module mem_resp_port
    import mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    input  logic        read_en,
    input  logic        write_en,
    input  logic        stall,
    output logic        hit,
    output mem_req_t    req,
    output logic        proto
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_RESP = RESP;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic [2:0] stalls;
    logic       request;
    logic       changed;

    assign request = read_en | write_en;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            stalls <= '0;
            req    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (request) begin
                        req    <= '{addr: addr, wdata: wdata, be: be, is_write: write_en};
                        stalls <= '0;
                        if (LATENCY == 1) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd1) begin
                        // Injected stalls only extend the final wait cycle, at most 7 times.
                        if (stall && stalls != 3'd7) begin
                            stalls <= stalls + 3'd1;
                        end else begin
                            state <= S_RESP;
                            cnt   <= '0;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign hit = (state == S_RESP);

    always_comb begin
        changed = (write_en != req.is_write) || (read_en == req.is_write) || (addr != req.addr);
        if (req.is_write && (wdata != req.wdata || be != req.be)) begin
            changed = 1'b1;
        end
    end

    assign proto = (read_en & write_en) | ((state == S_WAIT) & changed);

endmodule

// File: rtl/mem_responder.sv
// Word-organised memory serving an imem (read) and dmem (byte-write/read) port.
// Optional stall injection: define MEM_RESPONDER_STALL_INJECT_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic clk,
    input  logic reset_n,
    mem_responder_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    mem_req_t          i_req, d_req;
    logic              i_hit, d_hit;
    logic              i_proto, d_proto;
    logic              i_stall, d_stall;
    logic [31:0]       i_off, d_off;
    logic              i_ok, d_ok;
    logic [IDX_W-1:0]  i_idx, d_idx;
    logic              unused_bits;

`ifdef MEM_RESPONDER_STALL_INJECT_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!reset_n) lfsr <= LFSR_SEED;
        else          lfsr <= lfsr_next(lfsr);
    end

    assign i_stall = lfsr[0];
    assign d_stall = lfsr[1];
`else
    assign i_stall = 1'b0;
    assign d_stall = 1'b0;
`endif

    mem_resp_port #(.LATENCY(LATENCY)) u_imem (
        .clk      (clk),
        .reset_n  (reset_n),
        .addr     (bus.imem_addr),
        .wdata    ('0),
        .be       ('0),
        .read_en  (bus.imem_read_en),
        .write_en (1'b0),
        .stall    (i_stall),
        .hit      (i_hit),
        .req      (i_req),
        .proto    (i_proto)
    );

    mem_resp_port #(.LATENCY(LATENCY)) u_dmem (
        .clk      (clk),
        .reset_n  (reset_n),
        .addr     (bus.dmem_addr),
        .wdata    (bus.dmem_data_i),
        .be       (bus.dmem_data_en),
        .read_en  (bus.dmem_read_en),
        .write_en (bus.dmem_write_en),
        .stall    (d_stall),
        .hit      (d_hit),
        .req      (d_req),
        .proto    (d_proto)
    );

    // Offsets wrap below BASE_ADDR, so one unsigned compare covers both bounds.
    assign i_off = i_req.addr - BASE_ADDR;
    assign d_off = d_req.addr - BASE_ADDR;
    assign i_ok  = i_off < SPAN;
    assign d_ok  = d_off < SPAN;
    assign i_idx = i_off[IDX_W+1:2];
    assign d_idx = d_off[IDX_W+1:2];

    assign unused_bits = ^{i_req.wdata, i_req.be, i_req.is_write};

    // Combinational reads see the array before this cycle's write: read-before-write.
    assign bus.imem_hit    = i_hit;
    assign bus.dmem_hit    = d_hit;
    assign bus.imem_data_o = (i_hit && i_ok) ? mem[i_idx] : '0;
    assign bus.dmem_data_o = (d_hit && !d_req.is_write && d_ok) ? mem[d_idx] : '0;

    always_ff @(posedge clk) begin
        if (reset_n && d_hit && d_req.is_write && d_ok) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (d_req.be[k]) mem[d_idx][8*k +: 8] <= d_req.wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.oob_err   <= 1'b0;
            bus.proto_err <= 1'b0;
        end else begin
            if ((i_hit && !i_ok) || (d_hit && !d_ok)) bus.oob_err <= 1'b1;
            if (i_proto || d_proto) bus.proto_err <= 1'b1;
        end
    end

endmodule
